// File: rtl/pc_sequencer_if.sv
// Instruction-memory and decode handshake bundle for pc_sequencer.
// master = sequencer side, slave = memory/decode/datapath side.
interface pc_sequencer_if;
    logic [15:0] next_pc;
    logic [15:0] npc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;

    modport master (
        input  next_pc, imem_ack, imem_rdata, instr_ready,
        output npc, imem_req, imem_addr, instr_valid, instr
    );

    modport slave (
        output next_pc, imem_ack, imem_rdata, instr_ready,
        input  npc, imem_req, imem_addr, instr_valid, instr
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter owner: fetches one instruction at a time, hands it to decode, loads next_pc on retire.
// Optional retired-instruction counter is built only when FETCH_PERF_EN is defined.
module pc_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter int          MAX_WAIT     = 15,
    parameter int          WAIT_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    pc_sequencer_if.master     bus,
    input  logic               halt,
    input  logic               redirect_valid,
    input  logic [15:0]        redirect_pc,
    output logic               fetch_err,
    output logic [31:0]        fetch_count
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_VALID  = 2'd1,
        ST_HALTED = 2'd2,
        ST_ERROR  = 2'd3
    } state_e;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_e              state_q, state_d;
    logic [15:0]         pc_q, pc_d;
    logic [15:0]         instr_q, instr_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                req_q, req_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    // Next-state, PC, captured instruction and wait counter; redirect outranks ack/retire.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        wait_d  = wait_q;
        case (state_q)
            ST_FETCH: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    wait_d  = {WAIT_W{1'b0}};
                    state_d = ST_FETCH;
                end else if (req_q) begin
                    if (bus.imem_ack) begin
                        instr_d = bus.imem_rdata;
                        wait_d  = {WAIT_W{1'b0}};
                        state_d = ST_VALID;
                    end else if (wait_q == WAIT_LAST) begin
                        wait_d  = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
                        state_d = ST_ERROR;
                    end else begin
                        wait_d  = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    // Request not yet raised (first cycle out of reset): nothing to count.
                    state_d = ST_FETCH;
                end
            end
            ST_VALID: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    wait_d  = {WAIT_W{1'b0}};
                    state_d = ST_FETCH;
                end else if (bus.instr_ready) begin
                    pc_d    = bus.next_pc;
                    state_d = halt ? ST_HALTED : ST_FETCH;
                end else begin
                    state_d = ST_VALID;
                end
            end
            ST_HALTED: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    wait_d  = {WAIT_W{1'b0}};
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_ERROR;
            end
        endcase
    end

    // Output flops are derived from the next state so every port is a plain register.
    always_comb begin
        req_d   = (state_d == ST_FETCH);
        valid_d = (state_d == ST_VALID);
        err_d   = err_q | (state_d == ST_ERROR);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_VECTOR;
            instr_q <= 16'h0000;
            wait_q  <= {WAIT_W{1'b0}};
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            wait_q  <= wait_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.npc         = pc_q;
    assign bus.imem_addr   = pc_q;
    assign bus.imem_req    = req_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign fetch_err       = err_q;

`ifdef FETCH_PERF_EN
    logic [31:0] count_q, count_d;
    logic        retire_s;

    // Retire = accepted instruction that was not overridden by a redirect.
    always_comb begin
        retire_s = (state_q == ST_VALID) && bus.instr_ready && !redirect_valid;
        if (retire_s) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = 32'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a fetch/retire reference model predicts requests and presentations.
module tb_pc_sequencer;
    localparam logic [15:0] RV = 16'h0010;
    localparam int          MW = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halt, redirect_valid, fetch_err;
    logic [15:0] redirect_pc;
    logic [31:0] fetch_count;
    logic        mem_en;
    int          lat_lo, lat_hi;
    int          tests = 0;
    int          fails = 0;

    pc_sequencer_if bus();

    pc_sequencer #(.RESET_VECTOR(RV), .MAX_WAIT(MW), .WAIT_W(8)) dut (
        .clk(clk), .reset(rst_n), .bus(bus), .halt(halt),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_err(fetch_err), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] pc; logic [15:0] word; } exp_t;
    exp_t q[$];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0010) return 16'hA5A5;
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!bus.instr_valid && n < 60) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.instr_valid), 32'd1);
    endtask

    // Memory: acks a pending request after a random number of request cycles.
    initial begin : memory
        int lat;
        lat = 1;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'h0000;
        forever begin
            tick();
            if (mem_en && bus.imem_req && lat == 0) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = mem_word(bus.imem_addr);
                lat = $urandom_range(lat_hi, lat_lo);
            end else begin
                bus.imem_ack = 1'b0;
                if (mem_en && bus.imem_req && lat > 0) lat--;
            end
        end
    end

    // Monitor + reference model: compare outputs against model state, then advance the model.
    initial begin : monitor
        bit          m_valid, m_halted, m_err, m_req;
        int          wc;
        int unsigned m_cnt;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_req", 32'(bus.imem_req), 32'd0);
                chk("rst_valid", 32'(bus.instr_valid), 32'd0);
                chk("rst_err", 32'(fetch_err), 32'd0);
                chk("rst_instr", 32'(bus.instr), 32'd0);
                chk("rst_count", fetch_count, 32'd0);
                q.delete();
                e.pc = RV; e.word = mem_word(RV);
                q.push_back(e);
                m_valid = 0; m_halted = 0; m_err = 0; wc = 0; m_cnt = 0;
            end else begin
                m_req = !m_err && !m_halted && !m_valid;
                chk("fetch_err", 32'(fetch_err), 32'(m_err));
                chk("imem_req", 32'(bus.imem_req), 32'(m_req));
                chk("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
`ifdef FETCH_PERF_EN
                chk("fetch_count", fetch_count, m_cnt);
`else
                chk("fetch_count", fetch_count, 32'd0);
`endif
                if (q.size() > 0 && (m_req || m_valid)) begin
                    chk("npc", 32'(bus.npc), 32'(q[0].pc));
                    if (m_req) chk("imem_addr", 32'(bus.imem_addr), 32'(q[0].pc));
                    if (m_valid) chk("instr", 32'(bus.instr), 32'(q[0].word));
                end
                if (redirect_valid && !m_err) begin
                    q.delete();
                    e.pc = redirect_pc; e.word = mem_word(redirect_pc);
                    q.push_back(e);
                    m_valid = 0; m_halted = 0; wc = 0;
                end else if (m_valid) begin
                    if (bus.instr_ready) begin
                        void'(q.pop_front());
                        m_cnt++;
                        m_valid = 0;
                        if (halt) begin
                            m_halted = 1;
                        end else begin
                            e.pc = bus.next_pc; e.word = mem_word(bus.next_pc);
                            q.push_back(e);
                        end
                    end
                end else if (m_req) begin
                    if (bus.imem_ack) begin
                        m_valid = 1;
                        wc = 0;
                    end else begin
                        wc++;
                        if (wc == MW) begin
                            m_err = 1;
                            q.delete();
                        end
                    end
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by a randomized run.
    initial begin : stim
        int n;
        rst_n = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
        bus.instr_ready = 1'b0; bus.next_pc = 16'h0000;
        mem_en = 1'b1; lat_lo = 1; lat_hi = 1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1 rst_n = 1'b1;

        // First fetch at RESET_VECTOR, then sequential next_pc.
        bus.instr_ready = 1'b1; bus.next_pc = 16'h0011;
        wait_valid("first_valid");
        chk("first_npc", 32'(bus.npc), 32'(RV));
        chk("first_instr", 32'(bus.instr), 32'hA5A5);
        repeat (6) tick();

        // Decode stall, then retire loading 0x0040.
        bus.instr_ready = 1'b0;
        wait_valid("stall_valid");
        repeat (5) tick();
        bus.instr_ready = 1'b1; bus.next_pc = 16'h0040;
        tick();
        bus.instr_ready = 1'b0;
        wait_valid("after_stall_valid");
        chk("stall_next_npc", 32'(bus.npc), 32'h0040);

        // Redirect beats a same-cycle retire.
        bus.instr_ready = 1'b1; bus.next_pc = 16'h1234;
        redirect_valid = 1'b1; redirect_pc = 16'h0200;
        tick();
        redirect_valid = 1'b0; bus.instr_ready = 1'b0;
        wait_valid("redir_valid");
        chk("redir_npc", 32'(bus.npc), 32'h0200);

        // PC wrap through 0xFFFF.
        bus.instr_ready = 1'b1; bus.next_pc = 16'hFFFF;
        tick();
        bus.instr_ready = 1'b0;
        wait_valid("wrap_valid_a");
        chk("wrap_npc_a", 32'(bus.npc), 32'hFFFF);
        bus.instr_ready = 1'b1; bus.next_pc = 16'h0000;
        tick();
        bus.instr_ready = 1'b0;
        wait_valid("wrap_valid_b");
        chk("wrap_npc_b", 32'(bus.npc), 32'h0000);

        // Halt at retire, then resume by redirect.
        bus.instr_ready = 1'b1; halt = 1'b1;
        tick();
        bus.instr_ready = 1'b0; halt = 1'b0;
        repeat (8) tick();
        chk("halted_no_req", 32'(bus.imem_req), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 16'h0005;
        tick();
        redirect_valid = 1'b0;
        wait_valid("resume_valid");
        chk("resume_npc", 32'(bus.npc), 32'h0005);

        // Randomized traffic.
        lat_lo = 0; lat_hi = 3;
        for (int i = 0; i < 3000; i++) begin
            bus.instr_ready = ($urandom_range(3, 0) != 0);
            bus.next_pc     = 16'($urandom);
            halt            = ($urandom_range(15, 0) == 0);
            redirect_valid  = ($urandom_range(31, 0) == 0);
            redirect_pc     = 16'($urandom);
            tick();
        end
        bus.instr_ready = 1'b0; halt = 1'b0; redirect_valid = 1'b0;

        // Fetch timeout: memory goes silent.
        mem_en = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 16'h0300;
        tick();
        redirect_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 100 && !fetch_err; i++) begin
            if (bus.imem_req) n++;
            tick();
        end
        chk("timeout_reached", 32'(fetch_err), 32'd1);
        chk("timeout_req_cycles", 32'(n), 32'(MW));
        redirect_valid = 1'b1; redirect_pc = 16'h0400;
        tick();
        redirect_valid = 1'b0;
        repeat (3) tick();
        chk("err_sticky", 32'(fetch_err), 32'd1);
        chk("err_no_req", 32'(bus.imem_req), 32'd0);

        // Reset clears the error; then async reset mid-fetch.
        rst_n = 1'b0;
        #1 chk("reset_clears_err", 32'(fetch_err), 32'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (3) tick();
        chk("pending_req", 32'(bus.imem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_req_drop", 32'(bus.imem_req), 32'd0);
        mem_en = 1'b1; lat_lo = 1; lat_hi = 1;
        @(negedge clk); #1 rst_n = 1'b1;
        bus.instr_ready = 1'b1; bus.next_pc = 16'h0011;
        wait_valid("restart_valid");
        chk("restart_npc", 32'(bus.npc), 32'(RV));
        chk("restart_count", fetch_count, 32'd0);
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Sequential owner of the program counter, sitting between the instruction memory and the combinational next-PC datapath.
- Holds the PC register and fetches the instruction at that PC through a req/ack memory port.
- Presents the instruction to decode with a valid/ready handshake.
- Exports the PC of the presented instruction as npc, and loads the datapath-computed next_pc on each accepted instruction.
- Keeps at most one instruction in flight; supports external redirect, halt, and fetch timeout.

Parameters:
RESET_VECTOR, 16'h0000, PC value loaded on reset
MAX_WAIT, 15, cycles the memory may take to acknowledge before fetch error (1..255)
WAIT_W, 8, width of the wait counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset
next_pc  input  16  next PC from the next-PC datapath, valid while instr_valid=1
npc  output  16  PC of the instruction currently held/presented (feeds the next-PC datapath)
imem_req  output  1  instruction memory request
imem_addr  output  16  word address of the request (equals npc)
imem_ack  input  1  memory acknowledge; imem_rdata valid in the same cycle
imem_rdata  input  16  fetched instruction word
instr_valid  output  1  instruction available to decode
instr  output  16  registered instruction word
instr_ready  input  1  decode accepts the instruction (instruction retires)
halt  input  1  sampled on retire; stops fetching after the current instruction
redirect_valid  input  1  external PC override (debug/exception)
redirect_pc  input  16  override target
fetch_err  output  1  sticky: memory timeout occurred
fetch_count  output  32  retired-instruction count (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - PC=RESET_VECTOR and state=FETCH.
  - instr=0, instr_valid=0, imem_req=0, fetch_err=0, wait counter=0.
- First request is issued in the first cycle after reset deasserts.
- States:
  - FETCH: imem_req=1, imem_addr=PC, instr_valid=0.
    - On imem_ack: instr<=imem_rdata; go to VALID; wait counter<=0.
    - No ack: wait counter +1. When counter reaches MAX_WAIT without ack, go to ERROR.
  - VALID: imem_req=0, instr_valid=1, instr stable.
    - On instr_ready=1 (retire): PC<=next_pc.
      - halt=1: go to HALTED.
      - Otherwise: go to FETCH.
    - Without instr_ready, hold indefinitely; npc and instr are unchanged.
  - HALTED: no requests, instr_valid=0; leaves only on redirect or reset.
  - ERROR: fetch_err=1, no requests, instr_valid=0; leaves only on reset.
- Redirect:
  - Highest priority in FETCH, VALID and HALTED; ignored in ERROR.
  - Effect: PC<=redirect_pc, instr_valid<=0, wait counter<=0, state<=FETCH.
  - A same-cycle imem_ack or instr_ready is discarded: instruction not retired, next_pc not loaded, count not incremented.
  - An outstanding request may be abandoned. The address changes the next cycle and the memory must tolerate this.
- Minimum fetch-to-retire latency is 2 cycles: ack in cycle N, instr_valid in N+1, ready in N+1, next req in N+2.
- PC arithmetic belongs to the external datapath. PC wraps modulo 2^16 with no special handling, so next_pc=16'hFFFF+1 gives 0.
- npc and imem_addr are direct register outputs with no combinational path from inputs.
- imem_req deasserts in the cycle after ack.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined: fetch_count is a 32-bit counter, reset to 0, +1 on each retire (VALID and instr_ready and not redirect_valid), wrapping at 2^32.
- Undefined: fetch_count is tied to 0 and no counter logic is generated.

Test Plan:
- Reset release, RESET_VECTOR=16'h0010, memory ack after 1 cycle with rdata=16'hA5A5, instr_ready=1, next_pc=16'h0011 -> imem_addr=16'h0010; instr=16'hA5A5 valid; next request addr=16'h0011; fetch_count=1.
- Decode stalls: instr_ready=0 for 5 cycles -> instr_valid stays 1, instr and npc constant, imem_req=0; retire on cycle 6 loads next_pc=16'h0040.
- Redirect in VALID with instr_ready=1, redirect_pc=16'h0200 -> PC=16'h0200, next_pc ignored, fetch_count unchanged, next imem_addr=16'h0200.
- Memory never acks, MAX_WAIT=15 -> fetch_err=1 after 15 cycles of imem_req, imem_req=0 afterward; redirect ignored; reset clears fetch_err.
- halt=1 at retire -> HALTED with no further requests; redirect_pc=16'h0005 resumes fetch at 16'h0005.
- Reset asserted mid-FETCH with an outstanding req -> imem_req drops immediately (asynchronous); after release, fetch restarts at RESET_VECTOR; fetch_count=0.
